// File: rtl/data_corrupt_ram_sync.sv
// Per-entry corrupt/poison flag store: DEPTH x WIDTH with valid bits, masked writes,
// flush, and a registered read port with write-first bypass.
module data_corrupt_ram_sync #(
  parameter  int DEPTH  = 8,
  parameter  int WIDTH  = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [WIDTH-1:0]  W0_mask,
  input  logic              flush
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] valid_flushed;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             wr_hit, rd_hit;
  logic [WIDTH-1:0] wr_old, wr_val;

  always_comb begin
    valid_flushed = flush ? '0 : valid_q;
    wr_hit        = W0_en && (int'(W0_addr) < DEPTH);
    rd_hit        = R0_en && (int'(R0_addr) < DEPTH);

    // Flush lands before the write, so a flushed entry merges against zero.
    wr_old = '0;
    if (wr_hit && valid_flushed[W0_addr]) wr_old = mem_q[W0_addr];
    wr_val = (W0_data & W0_mask) | (wr_old & ~W0_mask);

    valid_d = valid_flushed;
    if (wr_hit) valid_d[W0_addr] = 1'b1;

    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (R0_en) begin
      rdata_d  = '0;
      rvalid_d = 1'b0;
      if (rd_hit && wr_hit && (R0_addr == W0_addr)) begin
        rdata_d  = wr_val;
        rvalid_d = 1'b1;
      end else if (rd_hit && valid_flushed[R0_addr]) begin
        rdata_d  = mem_q[R0_addr];
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Data array is deliberately unreset; the valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (wr_hit) mem_q[W0_addr] <= wr_val;
  end

  assign R0_data  = rdata_q;
  assign R0_valid = rvalid_q;

endmodule

// File: doc/data_corrupt_ram_sync.md
Name: data_corrupt_ram_sync

Overview:
- Parametrised single-clock successor to the fixed 8x1 corrupt-flag memory used alongside data arrays.
- Stores DEPTH entries of WIDTH bits, each with a per-entry valid bit cleared by reset or flush.
- Reads are registered with write-first bypass; writes support a bit mask.
- Sits beside the L1/L2 data arrays to track per-beat corrupt and poison flags so that stale entries never read back as corrupt after reset or flush.

Parameters:
- DEPTH, 8, number of entries; any value >= 2, not required to be a power of two.
- WIDTH, 1, bits per entry.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- R0_addr  input  ADDR_W  read address.
- R0_en  input  1  read enable.
- R0_data  output  WIDTH  registered read data.
- R0_valid  output  1  registered: the entry read was valid.
- W0_addr  input  ADDR_W  write address.
- W0_en  input  1  write enable.
- W0_data  input  WIDTH  write data.
- W0_mask  input  WIDTH  per-bit write enable; 1 = bit written.
- flush  input  1  clear all valid bits.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - valid array cleared to 0.
  - R0_data = 0, R0_valid = 0.
  - Data array is not reset.
- Effective entry value: stored data if valid, else all-zero. An invalid entry always reads R0_data = 0, R0_valid = 0.
- Write at edge t, when W0_en = 1 and W0_addr < DEPTH:
  - new = (W0_data & W0_mask) | (old_effective & ~W0_mask).
  - valid[W0_addr] is set to 1, even when W0_mask = 0.
  - A partial write to an invalid entry therefore zero-fills the unmasked bits.
- Write with W0_addr >= DEPTH: ignored, no state change.
- Flush at edge t: all valid bits are cleared. If a write occurs in the same cycle, the write is applied after the flush, so the written entry ends valid with unmasked bits = 0.
- Read latency is 1 cycle. With R0_en = 1 at cycle t, R0_data and R0_valid at t+1 reflect the state after all cycle-t updates:
  - Flush, then write, are both included (write-first bypass, merged per mask).
  - Read of an address that was flushed at t and not written at t gives 0 / 0.
- R0_addr >= DEPTH with R0_en = 1: output 0 / 0 next cycle.
- R0_en = 0: R0_data and R0_valid hold their previous values.
- No stalls and no backpressure. One read and one write may occur every cycle, to any addresses including the same one.
- Reset asserted mid-operation:
  - Outputs and valid bits clear immediately (async).
  - A read issued in the reset cycle returns 0 / 0.
  - A write coincident with reset is dropped.
- No X propagation: outputs are never X after reset, whether the entry was written or not.

Test Plan:
- Reset, then read all DEPTH=8 addresses -> every R0_data = 0, R0_valid = 0, one cycle after each R0_en.
- Write addr 3 data 1 mask 1; next cycle read 3 -> following cycle R0_data = 1, R0_valid = 1. Read 4 -> R0_data = 0, R0_valid = 0. Drop R0_en -> outputs hold.
- WIDTH=4: write addr 2 = 4'hA mask 4'hF, then write addr 2 = 4'h5 mask 4'h3 -> read gives 4'h9. Write invalid addr 5 = 4'hF mask 4'h4 -> read gives 4'h4, R0_valid = 1.
- Same-cycle read and write to addr 6 with data 4'hC mask 4'hF, old value 4'h3 -> R0_data = 4'hC next cycle (bypass). Addr 7 with mask 4'h0 on an invalid entry -> R0_data = 0, R0_valid = 1.
- Fill all entries, pulse flush while writing addr 1 = 1 and reading addr 0 -> read 0 returns 0 / 0. Later read 1 -> 1 / 1. Read 2 -> 0 / 0.
- DEPTH=6: write and read addr 7 -> no state change, read 0 / 0. Assert reset asynchronously mid-stream between edges -> R0_valid drops immediately, all entries read 0 / 0 afterwards.
